// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: opcode constants and sequencer state encoding shared by the pipeline control logic
package core_ctrl_pkg;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    MEM_WAIT = 2'd2
  } state_t;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: load-use hazard between the EX load and the register sources actually read by the ID instruction
//   opcode/rs1/rs2 : fields of the ID instruction
//   ex_memread/ex_rd : EX instruction is a load, and its destination
//   hazard : ID must wait one cycle for the load result
module hazard_detect
  import core_ctrl_pkg::*;
(
  input  logic [6:0] opcode,
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  output logic       hazard
);
  logic use_rs1, use_rs2;
  assign use_rs1 = opcode inside {OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_REG};
  assign use_rs2 = opcode inside {OP_STORE, OP_BRANCH, OP_REG};
  // x0 is hardwired to zero, so a load into it never creates a dependency
  assign hazard = ex_memread && ex_rd != 5'd0 &&
                  ((use_rs1 && rs1 == ex_rd) || (use_rs2 && rs2 == ex_rd));
endmodule

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones instead of wrapping
//   clk/rst : clock, synchronous active-high clear
//   inc     : count this cycle
//   count   : current value
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);
  always_ff @(posedge clk)
    if (rst) count <= '0;
    else if (inc && !(&count)) count <= count + 1'b1;
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: 5-stage pipeline sequencer producing PC/pipeline write enables, ID/EX bubble and IF/ID flush
//   clk_i/rst_i       : clock, synchronous active-high reset
//   start_i           : core run enable
//   id_instr_i        : ID-stage instruction word
//   ex_memread_i/ex_rd_i : EX load indication and destination
//   id_branch_taken_i : ID branch resolved taken
//   mem_stall_i       : data cache busy
//   pc_we_o/ifid_we_o/back_we_o : write enables; ifid_flush_o/idex_bubble_o : squash controls
//   state_o           : IDLE/RUN/MEM_WAIT; stall_cnt_o/flush_cnt_o : saturating event counters
module pipe_hazard_ctrl
  import core_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      id_instr_i,
  input  logic             ex_memread_i,
  input  logic [4:0]       ex_rd_i,
  input  logic             id_branch_taken_i,
  input  logic             mem_stall_i,
  output logic             pc_we_o,
  output logic             ifid_we_o,
  output logic             ifid_flush_o,
  output logic             idex_bubble_o,
  output logic             back_we_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);
  state_t state;
  logic hazard, active, go, in_run;
  logic unused_bits;
  assign unused_bits = ^{id_instr_i[31:25], id_instr_i[14:7]};
  hazard_detect u_hazard (
    .opcode     (id_instr_i[6:0]),
    .rs1        (id_instr_i[19:15]),
    .rs2        (id_instr_i[24:20]),
    .ex_memread (ex_memread_i),
    .ex_rd      (ex_rd_i),
    .hazard     (hazard)
  );
  // dropping start_i wins over any cache stall transition
  always_ff @(posedge clk_i)
    if (rst_i) state <= IDLE;
    else state <= (state == IDLE) ? (start_i ? RUN : IDLE) :
                  !start_i ? IDLE : mem_stall_i ? MEM_WAIT : RUN;
  assign active = state != IDLE;
  assign in_run = state == RUN;
  assign go     = active && !mem_stall_i;
  assign pc_we_o       = go && !hazard;
  assign ifid_we_o     = go && !hazard;
  assign back_we_o     = go;
  // squash controls stay quiet for the whole MEM_WAIT residency, including its exit cycle
  assign idex_bubble_o = go && hazard && in_run;
  assign ifid_flush_o  = go && !hazard && id_branch_taken_i && in_run;
  assign state_o = state;
  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (active && !pc_we_o),
    .count (stall_cnt_o)
  );
  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk_i),
    .rst   (rst_i),
    .inc   (ifid_flush_o),
    .count (flush_cnt_o)
  );
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed scoreboard bench for pipe_hazard_ctrl with 4-bit counters
module tb_pipe_hazard_ctrl;
  typedef struct packed {
    logic [1:0] st;
    logic       pc, ifid, fl, bub, back;
    logic [3:0] sc, fc;
  } exp_t;
  localparam logic [31:0] NOP      = 32'h0000_0000;
  localparam logic [31:0] ADDI_X5  = 32'h0012_8313;
  localparam logic [31:0] ADDI_X0  = 32'h0010_0313;
  localparam logic [31:0] ADDI_IM6 = 32'h0062_8313;
  localparam logic [31:0] SW_X6    = 32'h0062_A023;
  localparam logic [31:0] LUI_X5   = 32'h0002_82B7;
  localparam logic [31:0] ADD_X6   = 32'h0062_80B3;
  localparam logic [31:0] BEQ_X5   = 32'h0072_8063;
  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, memread = 1'b0, br = 1'b0, ms = 1'b0;
  logic [31:0] instr = '0;
  logic [4:0] rd = '0;
  logic pc_we, ifid_we, flush, bubble, back_we;
  logic [1:0] state;
  logic [3:0] stall_cnt, flush_cnt;
  exp_t q[$];
  exp_t e, act;
  int checks = 0, errors = 0, cyc = 0;
  bit done = 0;
  pipe_hazard_ctrl #(.CNT_W(4)) dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .start_i           (start),
    .id_instr_i        (instr),
    .ex_memread_i      (memread),
    .ex_rd_i           (rd),
    .id_branch_taken_i (br),
    .mem_stall_i       (ms),
    .pc_we_o           (pc_we),
    .ifid_we_o         (ifid_we),
    .ifid_flush_o      (flush),
    .idex_bubble_o     (bubble),
    .back_we_o         (back_we),
    .state_o           (state),
    .stall_cnt_o       (stall_cnt),
    .flush_cnt_o       (flush_cnt)
  );
  always #5 clk = ~clk;
  function automatic exp_t mk(input int st, pc, ifid, fl, bub, back, sc, fc);
    mk = {st[1:0], pc[0], ifid[0], fl[0], bub[0], back[0], sc[3:0], fc[3:0]};
  endfunction
  task automatic step(input logic r, s, input logic [31:0] ins, input logic mr,
                      input logic [4:0] d, input logic b, m, input exp_t x);
    @(posedge clk);
    #1;
    rst = r; start = s; instr = ins; memread = mr; rd = d; br = b; ms = m;
    q.push_back(x);
  endtask
  always @(negedge clk) begin
    act = {state, pc_we, ifid_we, flush, bubble, back_we, stall_cnt, flush_cnt};
    if (q.size() != 0) begin
      e = q.pop_front();
      cyc++;
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL step%0d st/pc/ifid/fl/bub/back/scnt/fcnt got %0d/%b/%b/%b/%b/%b/%0d/%0d want %0d/%b/%b/%b/%b/%b/%0d/%0d",
                 cyc, act.st, act.pc, act.ifid, act.fl, act.bub, act.back, act.sc, act.fc,
                 e.st, e.pc, e.ifid, e.fl, e.bub, e.back, e.sc, e.fc);
      end
    end else if (done) begin
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end
  initial begin
    #100000;
    $display("FAIL timeout bench did not complete");
    $fatal(1);
  end
  initial begin
    step(1, 0, NOP,      0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    step(0, 1, ADDI_X5,  1, 5, 1, 0, mk(0, 0, 0, 0, 0, 0, 0, 0));
    step(0, 1, NOP,      0, 0, 0, 0, mk(1, 1, 1, 0, 0, 1, 0, 0));
    step(0, 1, ADDI_X5,  1, 5, 0, 0, mk(1, 0, 0, 0, 1, 1, 0, 0));
    step(0, 1, ADDI_X0,  1, 0, 0, 0, mk(1, 1, 1, 0, 0, 1, 1, 0));
    step(0, 1, ADDI_IM6, 1, 6, 0, 0, mk(1, 1, 1, 0, 0, 1, 1, 0));
    step(0, 1, SW_X6,    1, 6, 0, 0, mk(1, 0, 0, 0, 1, 1, 1, 0));
    step(0, 1, ADDI_X5,  0, 5, 0, 0, mk(1, 1, 1, 0, 0, 1, 2, 0));
    step(0, 1, LUI_X5,   1, 5, 0, 0, mk(1, 1, 1, 0, 0, 1, 2, 0));
    step(0, 1, ADD_X6,   1, 6, 0, 0, mk(1, 0, 0, 0, 1, 1, 2, 0));
    step(0, 1, BEQ_X5,   1, 5, 1, 0, mk(1, 0, 0, 0, 1, 1, 3, 0));
    step(0, 1, BEQ_X5,   0, 5, 1, 0, mk(1, 1, 1, 1, 0, 1, 4, 0));
    step(0, 1, NOP,      0, 0, 0, 0, mk(1, 1, 1, 0, 0, 1, 4, 1));
    step(0, 1, NOP,      0, 0, 0, 1, mk(1, 0, 0, 0, 0, 0, 4, 1));
    step(0, 1, BEQ_X5,   0, 0, 1, 1, mk(2, 0, 0, 0, 0, 0, 5, 1));
    step(0, 1, NOP,      0, 0, 0, 1, mk(2, 0, 0, 0, 0, 0, 6, 1));
    step(0, 1, NOP,      0, 0, 0, 1, mk(2, 0, 0, 0, 0, 0, 7, 1));
    step(0, 1, BEQ_X5,   0, 0, 1, 0, mk(2, 1, 1, 0, 0, 1, 8, 1));
    step(0, 1, NOP,      0, 0, 0, 0, mk(1, 1, 1, 0, 0, 1, 8, 1));
    step(0, 0, NOP,      0, 0, 0, 1, mk(1, 0, 0, 0, 0, 0, 8, 1));
    step(0, 0, NOP,      0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 9, 1));
    step(0, 1, NOP,      0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0, 9, 1));
    step(0, 1, NOP,      0, 0, 0, 1, mk(1, 0, 0, 0, 0, 0, 9, 1));
    step(1, 1, NOP,      0, 0, 0, 1, mk(2, 0, 0, 0, 0, 0, 10, 1));
    step(0, 1, NOP,      0, 0, 0, 1, mk(0, 0, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 20; k++)
      step(0, 1, NOP, 0, 0, 0, 1, mk(k == 0 ? 1 : 2, 0, 0, 0, 0, 0, k > 15 ? 15 : k, 0));
    step(0, 1, NOP,      0, 0, 0, 0, mk(2, 1, 1, 0, 0, 1, 15, 0));
    step(0, 1, NOP,      0, 0, 0, 0, mk(1, 1, 1, 0, 0, 1, 15, 0));
    @(posedge clk);
    #1;
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL final stall_cnt got %0d want 15", stall_cnt);
    end
    checks++;
    if (flush_cnt !== 4'd0) begin
      errors++;
      $display("FAIL final flush_cnt got %0d want 0", flush_cnt);
    end
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL final state got %0d want 1", state);
    end
    done = 1;
  end
endmodule
